memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the ports are named as follows.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 inst_v_x  in  1  execute-stage result valid this cycle.
REQ-005 minst  in  4  memory op: 0fff = load with funct3 fff; 10ff = store SB/SH/SW with funct3 {0,ff}; 11xx = no memory op.
REQ-006 addr_x  in  32  execute result: effective address for memory ops, writeback data otherwise.
REQ-007 st_data_x  in  32  store data (rs2 value).
REQ-008 rd_x  in  5  destination register.
REQ-009 rdm_v_x  in  1  destination write enable.
REQ-010 hazard_m  out  1  stall: upstream holds its instruction while high.
REQ-011 dmem_req, dmem_we  out  1,1  bus request and write flag.
REQ-012 dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-013 dmem_be, dmem_wdata  out  4,32  byte enables and lane-replicated write data.
REQ-014 dmem_ready  in  1  bus accepts the request when it and dmem_req are high.
REQ-015 dmem_rvalid, dmem_rdata  in  1,32  load response.
REQ-016 wb_v, wb_rd, wb_data  out  1,5,32  register writeback, valid for one cycle.
REQ-017 misalign  out  1  one-cycle pulse when a misaligned access is dropped.

Function
REQ-018 M register: SHALL capture inst_v_x, minst, addr_x, st_data_x, rd_x and rdm_v_x on clk when hazard_m=0; SHALL hold when hazard_m=1.
REQ-019 FSM states: IDLE, REQ, WAIT.
REQ-020 IDLE plus a valid captured memory op (aligned) -> REQ. A non-memory op SHALL stay in IDLE and drive wb_v=rdm_v, wb_data=addr the same cycle (latency 1 from capture).
REQ-021 REQ: dmem_req=1 until dmem_ready. Store handshake -> IDLE. Load handshake -> WAIT.
REQ-022 WAIT: on dmem_rvalid, drive wb_v=rdm_v and wb_data=extracted load data, then -> IDLE. dmem_rvalid in the same cycle as the handshake is not allowed; the bus guarantees at least one cycle of latency.
REQ-023 hazard_m=1 in REQ, and in WAIT while dmem_rvalid=0; hazard_m=0 otherwise.
REQ-024 Load extract: byte lane = addr[1:0], halfword lane = addr[1].
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend.
  - LW: whole word.
REQ-025 Store enables:
  - SB: be = 0001<<addr[1:0], wdata = byte replicated x4.
  - SH: be = 0011<<{addr[1],0}, wdata = half replicated x2.
  - SW: be = 1111.
  - Loads: be = 1111, dmem_we = 0.
REQ-026 Misaligned op (halfword with addr[0]=1, or word with addr[1:0]!=0): no bus request, no writeback, misalign=1 for one cycle, FSM stays IDLE.
REQ-027 wb_v SHALL be 0 whenever rd=0 or rdm_v=0, regardless of op.
REQ-028 dmem_addr, dmem_be, dmem_we and dmem_wdata SHALL stay stable while dmem_req=1 and dmem_ready=0.
REQ-029 Invalid funct3 values (load 011/110/111, store 011) SHALL be treated as no memory op, with no writeback.

Reset
REQ-030 reset=0 SHALL immediately set: FSM=IDLE, M valid=0, hazard_m=0, dmem_req=0, dmem_we=0, wb_v=0, misalign=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the access; a later dmem_rvalid SHALL be ignored until a new load reaches WAIT.

Verification
REQ-032 ALU op: rd=5, addr_x=0x1234, minst=1100 -> wb_v=1, wb_rd=5, wb_data=0x1234 one cycle after capture, hazard_m=0.
REQ-033 LB: addr=0x103, dmem_ready=0 for 2 cycles, rvalid after 1 more cycle with rdata=0x80FF_FF00 -> dmem_addr=0x100, hazard_m high for 4 cycles, wb_data=0xFFFF_FF80.
REQ-034 SH: addr=0x202, st_data=0x0000_ABCD -> dmem_we=1, be=1100, wdata=0xABCD_ABCD, no writeback.
REQ-035 LW: addr=0x301 -> misalign pulse, dmem_req stays 0, wb_v=0, next instruction accepted the following cycle.
REQ-036 Reset=0 during WAIT, release, stray rvalid -> wb_v stays 0, FSM=IDLE.
REQ-037 LHU: addr=0x402, rdata=0x8001_0000, rd=0 -> dmem transaction occurs, wb_v=0.

Source files
------------

// File: rtl/memory_access.sv
// Memory stage: registers the execute result, runs the data bus handshake,
// aligns load data and store lanes, and produces register writeback.
module memory_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_v_x,
    input  logic [3:0]  minst,
    input  logic [31:0] addr_x,
    input  logic [31:0] st_data_x,
    input  logic [4:0]  rd_x,
    input  logic        rdm_v_x,
    output logic        hazard_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_v,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic        m_v;
    logic [3:0]  m_op;
    logic [31:0] m_addr;
    logic [31:0] m_sd;
    logic [4:0]  m_rd;
    logic        m_rdv;

    logic        m_mem;
    logic        m_alu;
    logic        m_ok;
    logic        wr_en;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld_data;

    function automatic logic op_valid(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
            4'b1000, 4'b1001, 4'b1010: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // op[1:0] is the access size for both loads and stores
    function automatic logic aligned(input logic [3:0] op,
                                     input logic [1:0] a);
        case (op[1:0])
            2'b01:   return !a[0];
            2'b10:   return a == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        m_mem    = op_valid(m_op);
        m_alu    = m_op[3:2] == 2'b11;
        m_ok     = aligned(m_op, m_addr[1:0]);
        wr_en    = m_rdv && (m_rd != 5'd0);
        hazard_m = (state == REQ) || ((state == WAIT) && !dmem_rvalid);
        dmem_req = state == REQ;
        dmem_we  = dmem_req && m_op[3];
        dmem_addr = {m_addr[31:2], 2'b00};
        misalign = (state == IDLE) && m_v && m_mem && !m_ok;
    end

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = m_sd;
        if (m_op[3]) begin
            unique case (1'b1)
                m_op[1:0] == 2'b00: begin
                    dmem_be    = 4'b0001 << m_addr[1:0];
                    dmem_wdata = {4{m_sd[7:0]}};
                end
                m_op[1:0] == 2'b01: begin
                    dmem_be    = 4'b0011 << {m_addr[1], 1'b0};
                    dmem_wdata = {2{m_sd[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = m_sd;
                end
            endcase
        end
    end

    always_comb begin
        lb = dmem_rdata[7:0];
        case (m_addr[1:0])
            2'b01:   lb = dmem_rdata[15:8];
            2'b10:   lb = dmem_rdata[23:16];
            2'b11:   lb = dmem_rdata[31:24];
            default: lb = dmem_rdata[7:0];
        endcase
        lh = m_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (m_op[2:0])
            3'b000:  ld_data = {{24{lb[7]}}, lb};
            3'b001:  ld_data = {{16{lh[15]}}, lh};
            3'b100:  ld_data = {24'd0, lb};
            3'b101:  ld_data = {16'd0, lh};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        wb_rd   = m_rd;
        wb_data = (state == WAIT) ? ld_data : m_addr;
        wb_v    = wr_en &&
                  (((state == IDLE) && m_v && m_alu) ||
                   ((state == WAIT) && dmem_rvalid));
    end

    // Issue is decided as the op is captured so the register never
    // gets overwritten before the bus request goes out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            m_v    <= 1'b0;
            m_op   <= 4'b1100;
            m_addr <= '0;
            m_sd   <= '0;
            m_rd   <= '0;
            m_rdv  <= 1'b0;
        end else if (!hazard_m) begin
            m_v    <= inst_v_x;
            m_op   <= minst;
            m_addr <= addr_x;
            m_sd   <= st_data_x;
            m_rd   <= rd_x;
            m_rdv  <= rdm_v_x;
            if (inst_v_x && op_valid(minst) && aligned(minst, addr_x[1:0]))
                state <= REQ;
            else
                state <= IDLE;
        end else if ((state == REQ) && dmem_ready) begin
            if (m_op[3]) begin
                state <= IDLE;
                m_v   <= 1'b0;
            end else begin
                state <= WAIT;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the memory stage: ALU pass-through, loads, stores,
// misaligned drops, invalid ops and reset mid-transaction.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_v_x;
    logic [3:0]  minst;
    logic [31:0] addr_x;
    logic [31:0] st_data_x;
    logic [4:0]  rd_x;
    logic        rdm_v_x;
    logic        hazard_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;

    int tests = 0;
    int fails = 0;
    int hcnt;

    always #5 clk = ~clk;

    memory_access dut (
        .clk        (clk),
        .reset      (reset),
        .inst_v_x   (inst_v_x),
        .minst      (minst),
        .addr_x     (addr_x),
        .st_data_x  (st_data_x),
        .rd_x       (rd_x),
        .rdm_v_x    (rdm_v_x),
        .hazard_m   (hazard_m),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .wb_v       (wb_v),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misalign   (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one instruction for a single capture edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd,
                         input logic rdv);
        inst_v_x  = 1'b1;
        minst     = op;
        addr_x    = a;
        st_data_x = sd;
        rd_x      = rd;
        rdm_v_x   = rdv;
        step();
        inst_v_x  = 1'b0;
    endtask

    // load with immediate accept and one cycle of read latency
    task automatic do_load(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic exp_v,
                           input logic [31:0] exp_d);
        dmem_ready = 1'b1;
        issue(op, a, 32'h0, rd, 1'b1);
        chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        step();
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        #1;
        chk({tag, "_wbv"}, {31'd0, wb_v}, {31'd0, exp_v});
        if (exp_v) chk({tag, "_data"}, wb_data, exp_d);
        step();
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        inst_v_x    = 1'b0;
        minst       = 4'b1100;
        addr_x      = '0;
        st_data_x   = '0;
        rd_x        = '0;
        rdm_v_x     = 1'b0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        step();
        step();
        chk("rst_hazard", {31'd0, hazard_m}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_wbv", {31'd0, wb_v}, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        reset = 1'b1;
        step();

        // ALU pass-through
        issue(4'b1100, 32'h1234, 32'h0, 5'd5, 1'b1);
        chk("alu_wbv", {31'd0, wb_v}, 32'd1);
        chk("alu_rd", {27'd0, wb_rd}, 32'd5);
        chk("alu_data", wb_data, 32'h1234);
        chk("alu_haz", {31'd0, hazard_m}, 32'd0);
        step();
        chk("alu_once", {31'd0, wb_v}, 32'd0);

        // LB with two stall cycles and delayed response
        hcnt = 0;
        issue(4'b0000, 32'h103, 32'h0, 5'd7, 1'b1);
        chk("lb_req", {31'd0, dmem_req}, 32'd1);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_we", {31'd0, dmem_we}, 32'd0);
        chk("lb_be", {28'd0, dmem_be}, 32'hf);
        hcnt += int'(hazard_m);
        step();
        chk("lb_addr_hold", dmem_addr, 32'h100);
        hcnt += int'(hazard_m);
        step();
        dmem_ready = 1'b1;
        #1;
        hcnt += int'(hazard_m);
        step();
        dmem_ready = 1'b0;
        chk("lb_req_drop", {31'd0, dmem_req}, 32'd0);
        hcnt += int'(hazard_m);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FF_FF00;
        #1;
        hcnt += int'(hazard_m);
        chk("lb_hcnt", hcnt, 32'd4);
        chk("lb_wbv", {31'd0, wb_v}, 32'd1);
        chk("lb_rd", {27'd0, wb_rd}, 32'd7);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        step();
        dmem_rvalid = 1'b0;
        #1;
        chk("lb_after", {31'd0, wb_v}, 32'd0);

        // SH upper half
        issue(4'b1001, 32'h202, 32'h0000_ABCD, 5'd3, 1'b1);
        chk("sh_we", {31'd0, dmem_we}, 32'd1);
        chk("sh_be", {28'd0, dmem_be}, 32'hc);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_addr", dmem_addr, 32'h200);
        chk("sh_wbv", {31'd0, wb_v}, 32'd0);
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        #1;
        chk("sh_done_req", {31'd0, dmem_req}, 32'd0);
        chk("sh_done_wbv", {31'd0, wb_v}, 32'd0);
        chk("sh_done_haz", {31'd0, hazard_m}, 32'd0);

        // SB lane 1
        issue(4'b1000, 32'h201, 32'h0000_0055, 5'd3, 1'b1);
        chk("sb_be", {28'd0, dmem_be}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h5555_5555);
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;

        // misaligned LW, then immediate follow-on
        issue(4'b0010, 32'h301, 32'h0, 5'd4, 1'b1);
        chk("lw_mis", {31'd0, misalign}, 32'd1);
        chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
        chk("lw_mis_wbv", {31'd0, wb_v}, 32'd0);
        chk("lw_mis_haz", {31'd0, hazard_m}, 32'd0);
        issue(4'b1100, 32'hBEEF, 32'h0, 5'd6, 1'b1);
        chk("mis_pulse", {31'd0, misalign}, 32'd0);
        chk("next_wbv", {31'd0, wb_v}, 32'd1);
        chk("next_data", wb_data, 32'hBEEF);

        // misaligned LH
        issue(4'b0001, 32'h401, 32'h0, 5'd4, 1'b1);
        chk("lh_mis", {31'd0, misalign}, 32'd1);
        chk("lh_mis_req", {31'd0, dmem_req}, 32'd0);

        // invalid funct3
        issue(4'b0011, 32'h500, 32'h0, 5'd8, 1'b1);
        chk("inv_ld_req", {31'd0, dmem_req}, 32'd0);
        chk("inv_ld_wbv", {31'd0, wb_v}, 32'd0);
        issue(4'b1011, 32'h500, 32'h0, 5'd8, 1'b1);
        chk("inv_st_req", {31'd0, dmem_req}, 32'd0);
        chk("inv_st_mis", {31'd0, misalign}, 32'd0);

        // ALU to x0
        issue(4'b1100, 32'h77, 32'h0, 5'd0, 1'b1);
        chk("alu_x0", {31'd0, wb_v}, 32'd0);

        // reset during WAIT
        dmem_ready = 1'b1;
        issue(4'b0010, 32'h600, 32'h0, 5'd9, 1'b1);
        step();
        dmem_ready = 1'b0;
        chk("wait_haz", {31'd0, hazard_m}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_haz", {31'd0, hazard_m}, 32'd0);
        chk("arst_req", {31'd0, dmem_req}, 32'd0);
        step();
        reset = 1'b1;
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        #1;
        chk("stray_wbv", {31'd0, wb_v}, 32'd0);
        chk("stray_haz", {31'd0, hazard_m}, 32'd0);
        step();
        dmem_rvalid = 1'b0;

        // load extraction variants
        do_load("lhu_x0", 4'b0101, 32'h402, 5'd0, 32'h8001_0000,
                1'b0, 32'h0);
        do_load("lhu", 4'b0101, 32'h402, 5'd10, 32'h8001_0000,
                1'b1, 32'h0000_8001);
        do_load("lh", 4'b0001, 32'h402, 5'd11, 32'h8001_0000,
                1'b1, 32'hFFFF_8001);
        do_load("lbu", 4'b0100, 32'h101, 5'd12, 32'h0000_8000,
                1'b1, 32'h0000_0080);
        do_load("lw", 4'b0010, 32'h700, 5'd13, 32'hDEAD_BEEF,
                1'b1, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
